// File: rtl/pipo_ctrl_pkg.sv
// Shared types and helpers for the round-robin PIPO holding-register controller.
package pipo_ctrl_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Ceiling log2, evaluated at elaboration time to size index ports.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipo_rr_ctrl_rr_arb.sv
// N-input round-robin arbiter; the pointer moves past the winner only when advance=1.
module rr_arb #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;
    int unsigned   idx;
    int unsigned   nxt;

    // Scan upward from the pointer, wrapping modulo N; first set request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[IW'(idx)]) begin
                found            = 1'b1;
                gnt[IW'(idx)]    = 1'b1;
                gnt_idx          = IW'(idx);
            end
        end
    end

    // Next pointer is one past the winner, wrapping to 0 after N-1.
    always_comb begin
        nxt = 32'(gnt_idx) + 1;
        if (nxt >= N) begin
            nxt = 0;
        end
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = IW'(nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pipo_rr_ctrl.sv
// Shares one W-bit holding register among N requesters via round-robin arbitration,
// presenting the captured word downstream under valid/ready.
module pipo_rr_ctrl
    import pipo_ctrl_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [N-1:0]          req,
    input  logic [N*W-1:0]        din,
    output logic [N-1:0]          gnt,
    output logic                  out_valid,
    output logic [W-1:0]          out_data,
    output logic [clog2(N)-1:0]   out_src,
    input  logic                  out_ready
);

    localparam int unsigned SW = clog2(N);

    state_t        state_q;
    state_t        state_d;
    logic          load_ok;
    logic          any_gnt;
    logic [N-1:0]  req_gated;
    logic [SW-1:0] gnt_idx;

    // A load may happen into an empty register or into a slot being consumed this cycle;
    // nothing is granted while reset is asserted.
    assign load_ok   = rst_ && ((state_q == EMPTY) || (out_valid && out_ready));
    assign req_gated = req & {N{load_ok}};
    assign any_gnt   = |gnt;
    assign out_valid = (state_q == FULL);

    rr_arb #(
        .N  (N),
        .IW (SW)
    ) u_arb (
        .clk     (clk),
        .rst_    (rst_),
        .req     (req_gated),
        .advance (any_gnt),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (any_gnt) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready && !any_gnt) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding register: captures the granted word and its source index.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            out_data <= '0;
            out_src  <= '0;
        end else if (any_gnt) begin
            out_data <= din[32'(gnt_idx)*W +: W];
            out_src  <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_pipo_rr_ctrl.sv
// Directed self-checking bench for pipo_rr_ctrl (N=4, W=4).
module tb_pipo_rr_ctrl;

    logic        clk;
    logic        rst_;
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;

    int checks;
    int errors;

    pipo_rr_ctrl #(.N(4), .W(4)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_ = 1'b0; req = 4'b1111; din = 16'h4321; out_ready = 1'b0;
        #2;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_src got=%0d exp=0", out_src); end
        tick();
        rst_ = 1'b1; req = 4'b0001; din = 16'h0003;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL post_reset_gnt got=%b exp=0001", gnt); end
        tick();
        req = 4'b0000;
        checks++; if (out_valid !== 1'b1 || out_data !== 4'h3) begin errors++; $display("FAIL first_load got v=%b d=%h exp v=1 d=3", out_valid, out_data); end
        // mid-transfer reset away from a clock edge
        #2 rst_ = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 4'h0) begin errors++; $display("FAIL async_reset got v=%b d=%h exp v=0 d=0", out_valid, out_data); end
        tick();
        rst_ = 1'b1; req = 4'b0001; din = 16'h0009;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rerelease_gnt got=%b exp=0001", gnt); end
        tick();
        out_ready = 1'b1; req = 4'b0000;
        #1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_drain got=%b exp=0", out_valid); end
    endtask

    // ptr=1, EMPTY on entry
    task automatic test_single;
        req = 4'b0100; din = 16'h0A00; out_ready = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        tick();
        req = 4'b0000;
        checks++; if (out_valid !== 1'b1 || out_data !== 4'hA || out_src !== 2'd2) begin
            errors++; $display("FAIL single_out got v=%b d=%h s=%0d exp v=1 d=a s=2", out_valid, out_data, out_src); end
        tick();
        checks++; if (out_valid !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL single_idle got v=%b g=%b exp v=0 g=0000", out_valid, gnt); end
    endtask

    // ptr=3 on entry; one grant to index 3 brings it to 0
    task automatic test_round_robin;
        logic [3:0] exp_g [5];
        logic [1:0] exp_s [5];
        logic [3:0] exp_d [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
        req = 4'b1000; din = 16'h4321; out_ready = 1'b1;
        tick();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (gnt !== exp_g[i]) begin errors++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, gnt, exp_g[i]); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_src !== exp_s[i] || out_data !== exp_d[i]) begin
                errors++; $display("FAIL rr_out[%0d] got v=%b s=%0d d=%h exp v=1 s=%0d d=%h", i, out_valid, out_src, out_data, exp_s[i], exp_d[i]); end
        end
    endtask

    // ptr=1, FULL on entry
    task automatic test_backpressure;
        req = 4'b0010; din = 16'h0050; out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 4'h5 || out_src !== 2'd1) begin errors++; $display("FAIL bp_setup got d=%h s=%0d exp d=5 s=1", out_data, out_src); end
        out_ready = 1'b0; req = 4'b0011; din = 16'h0076;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt[%0d] got=%b exp=0000", i, gnt); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 4'h5 || out_src !== 2'd1) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d exp v=1 d=5 s=1", i, out_valid, out_data, out_src); end
        end
        out_ready = 1'b1;
        #1;
        // ptr=2: scan 2,3,0 -> index 0
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL bp_release_gnt got=%b exp=0001", gnt); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 4'h6 || out_src !== 2'd0) begin
            errors++; $display("FAIL bp_release_out got v=%b d=%h s=%0d exp v=1 d=6 s=0", out_valid, out_data, out_src); end
    endtask

    // ptr=1, FULL on entry
    task automatic test_drain;
        req = 4'b0000; out_ready = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL drain_gnt got=%b exp=0000", gnt); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== 4'h6) begin errors++; $display("FAIL drain_out got v=%b d=%h exp v=0 d=6", out_valid, out_data); end
        req = 4'b1111;
        #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL drain_ptr got=%b exp=0010", gnt); end
    endtask

    // ptr=1, EMPTY on entry
    task automatic test_wrap;
        req = 4'b0100; din = 16'h0B0C; out_ready = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_setup got=%b exp=0100", gnt); end
        tick();
        req = 4'b0101;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt got=%b exp=0001", gnt); end
        tick();
        checks++; if (out_src !== 2'd0 || out_data !== 4'hC) begin errors++; $display("FAIL wrap_out got s=%0d d=%h exp s=0 d=c", out_src, out_data); end
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL skip_gnt got=%b exp=0100", gnt); end
        tick();
        req = 4'b0000;
        checks++; if (out_src !== 2'd2 || out_data !== 4'hB || out_valid !== 1'b1) begin
            errors++; $display("FAIL skip_out got v=%b s=%0d d=%h exp v=1 s=2 d=b", out_valid, out_src, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL final_drain got=%b exp=0", out_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drain();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
